// File: rtl/cu_pkg.sv
// Shared opcodes, state encoding, instruction classes and output bit positions
// for the Mini SRC hardwired control sequencer.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef struct packed {
        logic alu3;
        logic imm;
        logic unary;
        logic muldiv;
        logic mem;
        logic br;
        logic jump;
        logic io;
        logic mov;
        logic nop;
        logic halt;
    } op_class_t;

    localparam int ALU_W = 13;

    // bus_out bit positions
    localparam int B_HIOUT = 10, B_LOOUT = 9, B_ZHIGHOUT = 8, B_ZLOWOUT = 7, B_PCOUT = 6;
    localparam int B_IROUT = 5, B_MDROUT = 4, B_INOUT = 3, B_COUT = 2, B_YOUT = 1, B_MAROUT = 0;
    // seq bit positions
    localparam int Q_READ = 3, Q_INCPC = 2, Q_READ_MEM = 1, Q_WRITE_MEM = 0;
    // alu_op bit positions
    localparam int A_AND = 12, A_OR = 11, A_ADD = 10, A_SUB = 9, A_MUL = 8, A_DIV = 7;
    localparam int A_SHR = 6, A_SHRA = 5, A_SHL = 4, A_ROR = 3, A_ROL = 2, A_NEG = 1, A_NOT = 0;
    // reg_sel bit positions
    localparam int S_GRA = 5, S_GRB = 4, S_GRC = 3, S_RIN = 2, S_ROUT = 1, S_BAOUT = 0;
    // reg_in bit positions
    localparam int I_HIIN = 9, I_LOIN = 8, I_PCIN = 7, I_IRIN = 6, I_ZIN = 5, I_YIN = 4;
    localparam int I_MARIN = 3, I_MDRIN = 2, I_CONIN = 1, I_OUT_PORTIN = 0;

    // Execute-step index of a T state; only meaningful for ST_T0..ST_T7.
    function automatic logic [3:0] step_of(state_t s);
        return 4'(s) - 4'(ST_T0);
    endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// Opcode to instruction-class and ALU-select one-hots; purely combinational.
// No flow control: outputs follow the opcode in the same cycle.
module opcode_decoder
    import cu_pkg::*;
(
    input  logic [4:0]       opcode,
    output op_class_t        cls,
    output logic [ALU_W-1:0] alu_sel
);

    always_comb begin
        cls     = '0;
        alu_sel = '0;
        case (opcode)
            OP_ADD:  begin cls.alu3   = 1'b1; alu_sel[A_ADD]  = 1'b1; end
            OP_SUB:  begin cls.alu3   = 1'b1; alu_sel[A_SUB]  = 1'b1; end
            OP_AND:  begin cls.alu3   = 1'b1; alu_sel[A_AND]  = 1'b1; end
            OP_OR:   begin cls.alu3   = 1'b1; alu_sel[A_OR]   = 1'b1; end
            OP_ROR:  begin cls.alu3   = 1'b1; alu_sel[A_ROR]  = 1'b1; end
            OP_ROL:  begin cls.alu3   = 1'b1; alu_sel[A_ROL]  = 1'b1; end
            OP_SHR:  begin cls.alu3   = 1'b1; alu_sel[A_SHR]  = 1'b1; end
            OP_SHRA: begin cls.alu3   = 1'b1; alu_sel[A_SHRA] = 1'b1; end
            OP_SHL:  begin cls.alu3   = 1'b1; alu_sel[A_SHL]  = 1'b1; end
            OP_ADDI: begin cls.imm    = 1'b1; alu_sel[A_ADD]  = 1'b1; end
            OP_ANDI: begin cls.imm    = 1'b1; alu_sel[A_AND]  = 1'b1; end
            OP_ORI:  begin cls.imm    = 1'b1; alu_sel[A_OR]   = 1'b1; end
            OP_NEG:  begin cls.unary  = 1'b1; alu_sel[A_NEG]  = 1'b1; end
            OP_NOT:  begin cls.unary  = 1'b1; alu_sel[A_NOT]  = 1'b1; end
            OP_MUL:  begin cls.muldiv = 1'b1; alu_sel[A_MUL]  = 1'b1; end
            OP_DIV:  begin cls.muldiv = 1'b1; alu_sel[A_DIV]  = 1'b1; end
            OP_LD, OP_LDI, OP_ST: cls.mem  = 1'b1;
            OP_BR:                cls.br   = 1'b1;
            OP_JR, OP_JAL:        cls.jump = 1'b1;
            OP_IN, OP_OUT:        cls.io   = 1'b1;
            OP_MFHI, OP_MFLO:     cls.mov  = 1'b1;
            OP_HALT:              cls.halt = 1'b1;
            default:              cls.nop  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the Mini SRC datapath.
// One step per clk, no wait states; reset aborts any step and forces RST.
module control_unit
    import cu_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic [10:0] bus_out,
    output logic [3:0]  seq,
    output logic [12:0] alu_op,
    output logic [5:0]  reg_sel,
    output logic [9:0]  reg_in,
    output logic        CON_RESET,
    output logic        run
);

    state_t            state, state_nxt;
    op_class_t         cls;
    logic [ALU_W-1:0]  alu_sel;
    logic [4:0]        opcode;
    logic [26:0]       unused_ir;
    logic [STEP_W-1:0] step, last_step;

    assign opcode    = IR[31:27];
    assign unused_ir = IR[26:0];
    assign step      = STEP_W'(step_of(state));

    opcode_decoder u_dec (
        .opcode  (opcode),
        .cls     (cls),
        .alu_sel (alu_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RST;
        else       state <= state_nxt;
    end

    always_comb begin
        last_step = STEP_W'(3);
        if (cls.alu3 || cls.imm)          last_step = STEP_W'(5);
        else if (cls.unary)               last_step = STEP_W'(4);
        else if (cls.muldiv || cls.br)    last_step = STEP_W'(6);
        else if (cls.mem)                 last_step = STEP_W'(opcode == OP_LDI ? 5 : 7);
        else if (cls.jump && opcode == OP_JAL) last_step = STEP_W'(4);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:               state_nxt = ST_T0;
            ST_HALT:              state_nxt = ST_HALT;
            ST_T0, ST_T1, ST_T2:  state_nxt = state_t'(4'(state) + 4'd1);
            default: begin
                if (cls.halt)               state_nxt = ST_HALT;
                else if (step == last_step) state_nxt = ST_T0;
                else                        state_nxt = state_t'(4'(state) + 4'd1);
            end
        endcase
    end

    always_comb begin
        bus_out   = '0;
        seq       = '0;
        alu_op    = '0;
        reg_sel   = '0;
        reg_in    = '0;
        CON_RESET = 1'b0;
        run       = 1'b1;
        case (state)
            ST_RST:  begin run = 1'b0; CON_RESET = 1'b1; end
            ST_HALT: run = 1'b0;
            ST_T0:   begin seq[Q_INCPC] = 1'b1; reg_in[I_MARIN] = 1'b1; reg_in[I_PCIN] = 1'b1; end
            ST_T1:   begin seq[Q_READ] = 1'b1; seq[Q_READ_MEM] = 1'b1; reg_in[I_MDRIN] = 1'b1; end
            ST_T2:   begin bus_out[B_MDROUT] = 1'b1; reg_in[I_IRIN] = 1'b1; end
            default: begin
                if (cls.alu3 || cls.imm) begin
                    case (state)
                        ST_T3: begin reg_sel[S_GRB] = 1'b1; reg_sel[S_ROUT] = 1'b1; reg_in[I_YIN] = 1'b1; end
                        ST_T4: begin
                            if (cls.imm) bus_out[B_COUT] = 1'b1;
                            else begin reg_sel[S_GRC] = 1'b1; reg_sel[S_ROUT] = 1'b1; end
                            alu_op = alu_sel; reg_in[I_ZIN] = 1'b1;
                        end
                        ST_T5: begin bus_out[B_ZLOWOUT] = 1'b1; reg_sel[S_GRA] = 1'b1; reg_sel[S_RIN] = 1'b1; end
                        default: ;
                    endcase
                end else if (cls.unary) begin
                    case (state)
                        ST_T3: begin reg_sel[S_GRB] = 1'b1; reg_sel[S_ROUT] = 1'b1; alu_op = alu_sel; reg_in[I_ZIN] = 1'b1; end
                        ST_T4: begin bus_out[B_ZLOWOUT] = 1'b1; reg_sel[S_GRA] = 1'b1; reg_sel[S_RIN] = 1'b1; end
                        default: ;
                    endcase
                end else if (cls.muldiv) begin
                    case (state)
                        ST_T3: begin reg_sel[S_GRA] = 1'b1; reg_sel[S_ROUT] = 1'b1; reg_in[I_YIN] = 1'b1; end
                        ST_T4: begin reg_sel[S_GRB] = 1'b1; reg_sel[S_ROUT] = 1'b1; alu_op = alu_sel; reg_in[I_ZIN] = 1'b1; end
                        ST_T5: begin bus_out[B_ZLOWOUT] = 1'b1; reg_in[I_LOIN] = 1'b1; end
                        ST_T6: begin bus_out[B_ZHIGHOUT] = 1'b1; reg_in[I_HIIN] = 1'b1; end
                        default: ;
                    endcase
                end else if (cls.mem) begin
                    // Effective address (Rb + C) is formed the same way for ld, ldi and st.
                    case (state)
                        ST_T3: begin reg_sel[S_GRB] = 1'b1; reg_sel[S_BAOUT] = 1'b1; reg_in[I_YIN] = 1'b1; end
                        ST_T4: begin bus_out[B_COUT] = 1'b1; alu_op[A_ADD] = 1'b1; reg_in[I_ZIN] = 1'b1; end
                        ST_T5: begin
                            bus_out[B_ZLOWOUT] = 1'b1;
                            if (opcode == OP_LDI) begin reg_sel[S_GRA] = 1'b1; reg_sel[S_RIN] = 1'b1; end
                            else reg_in[I_MARIN] = 1'b1;
                        end
                        ST_T6: begin
                            reg_in[I_MDRIN] = 1'b1;
                            if (opcode == OP_ST) begin reg_sel[S_GRA] = 1'b1; reg_sel[S_ROUT] = 1'b1; end
                            else begin seq[Q_READ] = 1'b1; seq[Q_READ_MEM] = 1'b1; end
                        end
                        ST_T7: begin
                            if (opcode == OP_ST) seq[Q_WRITE_MEM] = 1'b1;
                            else begin bus_out[B_MDROUT] = 1'b1; reg_sel[S_GRA] = 1'b1; reg_sel[S_RIN] = 1'b1; end
                        end
                        default: ;
                    endcase
                end else if (cls.br) begin
                    case (state)
                        ST_T3: begin reg_sel[S_GRA] = 1'b1; reg_sel[S_ROUT] = 1'b1; reg_in[I_CONIN] = 1'b1; end
                        ST_T4: begin bus_out[B_PCOUT] = 1'b1; reg_in[I_YIN] = 1'b1; end
                        ST_T5: begin bus_out[B_COUT] = 1'b1; alu_op[A_ADD] = 1'b1; reg_in[I_ZIN] = 1'b1; end
                        ST_T6: begin bus_out[B_ZLOWOUT] = 1'b1; CON_RESET = 1'b1; reg_in[I_PCIN] = CON_FF; end
                        default: ;
                    endcase
                end else if (cls.jump) begin
                    if (opcode == OP_JAL && state == ST_T3) begin
                        bus_out[B_PCOUT] = 1'b1; reg_sel[S_GRB] = 1'b1; reg_sel[S_RIN] = 1'b1;
                    end else begin
                        reg_sel[S_GRA] = 1'b1; reg_sel[S_ROUT] = 1'b1; reg_in[I_PCIN] = 1'b1;
                    end
                end else if (cls.io) begin
                    reg_sel[S_GRA] = 1'b1;
                    if (opcode == OP_IN) begin bus_out[B_INOUT] = 1'b1; reg_sel[S_RIN] = 1'b1; end
                    else begin reg_sel[S_ROUT] = 1'b1; reg_in[I_OUT_PORTIN] = 1'b1; end
                end else if (cls.mov) begin
                    reg_sel[S_GRA] = 1'b1; reg_sel[S_RIN] = 1'b1;
                    if (opcode == OP_MFHI) bus_out[B_HIOUT] = 1'b1;
                    else bus_out[B_LOOUT] = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomised and directed instruction streams against a per-instruction
// micro-step model built from the control tables.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        CON_FF = 1'b0;
    logic [10:0] bus_out;
    logic [3:0]  seq;
    logic [12:0] alu_op;
    logic [5:0]  reg_sel;
    logic [9:0]  reg_in;
    logic        CON_RESET, run;

    int n_chk = 0;
    int n_fail = 0;
    logic [45:0] q[$];

    control_unit #(.STEP_W(3)) dut (
        .clk(clk), .reset(reset), .IR(IR), .CON_FF(CON_FF),
        .bus_out(bus_out), .seq(seq), .alu_op(alu_op), .reg_sel(reg_sel),
        .reg_in(reg_in), .CON_RESET(CON_RESET), .run(run)
    );

    always #5 clk = ~clk;

    // Flattened control word: {bus_out, seq, alu_op, reg_sel, reg_in, CON_RESET, run}
    logic [45:0] cw;
    assign cw = {bus_out, seq, alu_op, reg_sel, reg_in, CON_RESET, run};

    localparam int P_RUN = 0, P_CONRST = 1, P_OUTP = 2, P_CONIN = 3, P_MDRIN = 4, P_MARIN = 5;
    localparam int P_YIN = 6, P_ZIN = 7, P_PCIN = 9, P_LOIN = 10, P_HIIN = 11;
    localparam int P_BAOUT = 12, P_ROUT = 13, P_RIN = 14, P_GRC = 15, P_GRB = 16, P_GRA = 17;
    localparam int P_NOT = 18, P_NEG = 19, P_ROL = 20, P_ROR = 21, P_SHL = 22, P_SHRA = 23;
    localparam int P_SHR = 24, P_DIV = 25, P_MUL = 26, P_SUB = 27, P_ADD = 28, P_OR = 29, P_AND = 30;
    localparam int P_WR = 31, P_RDM = 32, P_INC = 33, P_READ = 34;
    localparam int P_COUT = 37, P_INOUT = 38, P_MDROUT = 39, P_PCOUT = 41, P_ZLO = 42, P_ZHI = 43;
    localparam int P_LOOUT = 44, P_HIOUT = 45;
    localparam int P_IRIN = 8;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [45:0] b(input int p);
        logic [45:0] one;
        one = 46'd1;
        return one << p;
    endfunction

    function automatic logic [45:0] alu_mask(input logic [4:0] op);
        case (op)
            5'd3, 5'd12:  return b(P_ADD);
            5'd4:         return b(P_SUB);
            5'd5, 5'd13:  return b(P_AND);
            5'd6, 5'd14:  return b(P_OR);
            5'd7:         return b(P_ROR);
            5'd8:         return b(P_ROL);
            5'd9:         return b(P_SHR);
            5'd10:        return b(P_SHRA);
            5'd11:        return b(P_SHL);
            5'd15:        return b(P_DIV);
            5'd16:        return b(P_MUL);
            5'd17:        return b(P_NEG);
            5'd18:        return b(P_NOT);
            default:      return '0;
        endcase
    endfunction

    // Cycles from one T0 to the next, from the timing table.
    function automatic int lat_of(input logic [4:0] op);
        case (op)
            5'd0, 5'd2:                 return 8;
            5'd15, 5'd16, 5'd19:        return 7;
            5'd17, 5'd18, 5'd21:        return 5;
            5'd20, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26,
            5'd28, 5'd29, 5'd30, 5'd31: return 4;
            default:                    return 6;
        endcase
    endfunction

    // Expected control word for every cycle of one instruction, fetch first.
    task automatic build(input logic [4:0] op, input logic cff);
        logic [45:0] r, a;
        r = b(P_RUN);
        a = alu_mask(op);
        q.delete();
        q.push_back(r | b(P_INC) | b(P_MARIN) | b(P_PCIN));
        q.push_back(r | b(P_READ) | b(P_RDM) | b(P_MDRIN));
        q.push_back(r | b(P_MDROUT) | b(P_IRIN));
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                q.push_back(r | b(P_GRB) | b(P_ROUT) | b(P_YIN));
                q.push_back(r | b(P_GRC) | b(P_ROUT) | a | b(P_ZIN));
                q.push_back(r | b(P_ZLO) | b(P_GRA) | b(P_RIN));
            end
            5'd12, 5'd13, 5'd14: begin
                q.push_back(r | b(P_GRB) | b(P_ROUT) | b(P_YIN));
                q.push_back(r | b(P_COUT) | a | b(P_ZIN));
                q.push_back(r | b(P_ZLO) | b(P_GRA) | b(P_RIN));
            end
            5'd17, 5'd18: begin
                q.push_back(r | b(P_GRB) | b(P_ROUT) | a | b(P_ZIN));
                q.push_back(r | b(P_ZLO) | b(P_GRA) | b(P_RIN));
            end
            5'd15, 5'd16: begin
                q.push_back(r | b(P_GRA) | b(P_ROUT) | b(P_YIN));
                q.push_back(r | b(P_GRB) | b(P_ROUT) | a | b(P_ZIN));
                q.push_back(r | b(P_ZLO) | b(P_LOIN));
                q.push_back(r | b(P_ZHI) | b(P_HIIN));
            end
            5'd0, 5'd1, 5'd2: begin
                q.push_back(r | b(P_GRB) | b(P_BAOUT) | b(P_YIN));
                q.push_back(r | b(P_COUT) | b(P_ADD) | b(P_ZIN));
                if (op == 5'd1) q.push_back(r | b(P_ZLO) | b(P_GRA) | b(P_RIN));
                else q.push_back(r | b(P_ZLO) | b(P_MARIN));
                if (op == 5'd0) begin
                    q.push_back(r | b(P_READ) | b(P_RDM) | b(P_MDRIN));
                    q.push_back(r | b(P_MDROUT) | b(P_GRA) | b(P_RIN));
                end else if (op == 5'd2) begin
                    q.push_back(r | b(P_GRA) | b(P_ROUT) | b(P_MDRIN));
                    q.push_back(r | b(P_WR));
                end
            end
            5'd19: begin
                q.push_back(r | b(P_GRA) | b(P_ROUT) | b(P_CONIN));
                q.push_back(r | b(P_PCOUT) | b(P_YIN));
                q.push_back(r | b(P_COUT) | b(P_ADD) | b(P_ZIN));
                q.push_back(r | b(P_ZLO) | b(P_CONRST) | (cff ? b(P_PCIN) : 46'd0));
            end
            5'd20: q.push_back(r | b(P_GRA) | b(P_ROUT) | b(P_PCIN));
            5'd21: begin
                q.push_back(r | b(P_PCOUT) | b(P_GRB) | b(P_RIN));
                q.push_back(r | b(P_GRA) | b(P_ROUT) | b(P_PCIN));
            end
            5'd22: q.push_back(r | b(P_INOUT) | b(P_GRA) | b(P_RIN));
            5'd23: q.push_back(r | b(P_GRA) | b(P_ROUT) | b(P_OUTP));
            5'd24: q.push_back(r | b(P_HIOUT) | b(P_GRA) | b(P_RIN));
            5'd25: q.push_back(r | b(P_LOOUT) | b(P_GRA) | b(P_RIN));
            default: q.push_back(r);
        endcase
    endtask

    task automatic check_inv(input string tag);
        chk({tag, " inv"}, {63'd0, ($countones(alu_op) <= 1) && !(seq[1] && seq[0])}, 64'd1);
    endtask

    // Entered and left at a negedge with the DUT showing T0.
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic cff);
        int lat;
        lat = -1;
        IR = ir;
        CON_FF = cff;
        build(ir[31:27], cff);
        for (int c = 0; c < 20; c++) begin
            if (c < q.size()) chk($sformatf("%s step%0d", tag, c), cw, q[c]);
            check_inv(tag);
            @(negedge clk);
            if (seq[2] && run) begin
                lat = c + 1;
                break;
            end
        end
        chk({tag, " latency"}, lat, lat_of(ir[31:27]));
    endtask

    initial begin
        logic [4:0] op;
        repeat (2) @(negedge clk);
        chk("reset state", cw, b(P_CONRST));
        reset = 1'b0;
        @(negedge clk);

        run_instr("add", 32'h18918000, 1'b0);
        run_instr("ld", 32'h01000095, 1'b0);
        run_instr("br taken", 32'h98800004, 1'b1);
        run_instr("br not taken", 32'h98800004, 1'b0);
        run_instr("mul", 32'h81880000, 1'b0);

        for (int n = 0; n < 120; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr($sformatf("rnd op%0d", op), {op, 27'($urandom)}, 1'($urandom_range(0, 1)));
        end

        // halt parks the sequencer until reset
        IR = 32'hD8000000;
        build(5'd27, 1'b0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("halt step%0d", c), cw, q[c]);
            @(negedge clk);
        end
        for (int c = 0; c < 20; c++) begin
            chk("halt idle", cw, 46'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("halt reset", cw, b(P_CONRST));
        reset = 1'b0;
        @(negedge clk);
        chk("halt restart", cw, b(P_RUN) | b(P_INC) | b(P_MARIN) | b(P_PCIN));

        // reset in T4 of st must abort before write_mem
        IR = 32'h11000010;
        build(5'd2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("st abort step%0d", c), cw, q[c]);
            if (c < 4) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("st abort outputs", cw, b(P_CONRST));
        chk("st abort write_mem", {63'd0, seq[0]}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        run_instr("st after abort", 32'h11000010, 1'b0);
        run_instr("add after st", 32'h18918000, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Mini SRC CPU datapath. It replaces the hand-stepped control stimulus and drives every datapath enable, ALU select, register-file select and memory strobe. It does this by decoding the instruction register through fixed fetch/execute step sequences. It sits beside `CPU` and connects one-to-one to that module's control ports.

## Interface
- `STEP_W`, default 3: width of the execute step counter; holds steps T0–T7.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `IR`  in  32  instruction register contents from the datapath; opcode is `IR[31:27]`.
- `CON_FF`  in  1  branch condition flip-flop output from the datapath.
- `bus_out`  out  11  {HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout}, MSB first.
- `seq`  out  4  {Read, IncPC, read_mem, write_mem}.
- `alu_op`  out  13  one-hot {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT}.
- `reg_sel`  out  6  {Gra, Grb, Grc, Rin, Rout, BAout}.
- `reg_in`  out  10  {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin}.
- `CON_RESET`  out  1  clears the CON flip-flop.
- `run`  out  1  high while the sequencer executes; low in HALT.

## Operation
- States: RST, T0–T7, HALT. Outputs are a pure decode of the state register, step and `IR`, and are valid for the whole cycle.
- `reset` high → next state RST. In RST all outputs are 0 except `CON_RESET`=1 and `run`=0. The cycle after `reset` falls → T0.
- Fetch:
  - T0: IncPC, MARin, PCin.
  - T1: Read, read_mem, MDRin.
  - T2: MDRout, IRin.
- Execute (from T3; `op` = the opcode's one-hot ALU bit). After an instruction's last listed step → T0.
- add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, op, Zin.
  - T5: Zlowout, Gra, Rin.
- addi 01100 (ADD), andi 01101 (AND), ori 01110 (OR):
  - T3: Grb, Rout, Yin.
  - T4: Cout, op, Zin.
  - T5: Zlowout, Gra, Rin.
- neg 10001, not 10010:
  - T3: Grb, Rout, op, Zin.
  - T4: Zlowout, Gra, Rin.
- mul 10000, div 01111:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- ld 00000, ldi 00001, st 00010, shared steps:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ADD, Zin.
- ldi:
  - T5: Zlowout, Gra, Rin.
- ld:
  - T5: Zlowout, MARin.
  - T6: Read, read_mem, MDRin.
  - T7: MDRout, Gra, Rin.
- st:
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin.
  - T7: write_mem.
- br 10011:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, ADD, Zin.
  - T6: Zlowout, CON_RESET; PCin only if `CON_FF`=1.
- jr 10100:
  - T3: Gra, Rout, PCin.
- jal 10101:
  - T3: PCout, Grb, Rin; the assembler encodes Rb=R15.
  - T4: Gra, Rout, PCin.
- in 10110:
  - T3: INout, Gra, Rin.
- out 10111:
  - T3: Gra, Rout, OUT_Portin.
- mfhi 11000:
  - T3: HIout, Gra, Rin.
- mflo 11001:
  - T3: LOout, Gra, Rin.
- nop 11010 and undefined opcodes 11100–11111: T3 drives nothing, then → T0.
- halt 11011: T3 → HALT. HALT drives all outputs 0 with `run`=0, and is left only via `reset`.

## Timing
- Each step lasts exactly one `clk` cycle; there are no wait states.
- Memory reads complete within the Read cycle.
- Instruction latency including fetch:
  - 4 cycles: jr, in, out, mfhi, mflo, nop.
  - 5 cycles: neg, not, jal.
  - 6 cycles: ALU and immediate ops, ldi.
  - 7 cycles: mul, div, br.
  - 8 cycles: ld, st.
- `IR` is decoded combinationally in T3–T7; it must stay stable from T2's edge until T0.
- `CON_FF` is sampled in T6, after CONin in T3.
- Reset has priority over every state, including mid-instruction and HALT. Outputs are 0 in the cycle after the reset edge, so no partial strobe leaks.
- At most one `alu_op` bit is high in any cycle; write_mem and read_mem are never high together.

## Structure
- Package `cu_pkg`:
  - 5-bit opcode constants listed above.
  - State encoding {RST, T0–T7, HALT}.
  - Bit-index constants for each output vector.
- Optional sub-module `opcode_decoder`: `IR[31:27]` → instruction-class one-hots (alu3, imm, unary, muldiv, mem, br, jump, io, mov, nop, halt).
- Top FSM `control_unit` = state register + step decode.

## Test plan
- Reset, then add R1,R2,R3 (IR=0x18918000) → T3 Grb/Rout/Yin; T4 Grc/Rout/ADD/Zin; T5 Zlowout/Gra/Rin; next cycle T0 with IncPC/MARin/PCin.
- ld R2,0x95(R0) → 8 cycles; read_mem high in T1 and T6 only; Gra/Rin in T7; no write_mem.
- br with `CON_FF`=1, then `CON_FF`=0 → PCin in T6 only in the taken case; CON_RESET=1 in T6 both times.
- mul R3,R1 → LOin in T5, HIin in T6, MUL one-hot in T4; 7-cycle latency.
- halt (opcode 11011) → `run` falls after T3; outputs stay 0 for 20 cycles; `reset` returns to T0 and `run`=1.
- Assert `reset` during T4 of st → next cycle all outputs 0 and no write_mem; fetch restarts cleanly.
